// File: rtl/fp_align_pkg.sv
// Shared widths, FSM state encoding and guard/round/sticky bundle for the
// FP adder pre-add alignment stage.
package fp_align_pkg;

  localparam int MAN_W     = 24;
  localparam int EXP_W     = 8;
  localparam int MAX_SHIFT = 26;
  localparam int SHIFT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    SHIFT,
    DONE
  } align_state_e;

  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;

endpackage

// File: rtl/fp_align_unit_shift.sv
// Combinational right shift of {man, g, r, s} by k bits (k <= MAX_SHIFT);
// bits leaving the round position fold into sticky.
module align_shift_stage
  import fp_align_pkg::*;
(
  input  logic [MAN_W-1:0]   man_in,
  input  grs_t               grs_in,
  input  logic [SHIFT_W-1:0] k,
  output logic [MAN_W-1:0]   man_out,
  output grs_t               grs_out
);

  always_comb begin
    man_out = man_in;
    grs_out = grs_in;
    for (int unsigned i = 0; i < MAX_SHIFT; i++) begin
      if (i < 32'(k)) begin
        grs_out.s = grs_out.s | grs_out.r;
        grs_out.r = grs_out.g;
        grs_out.g = man_out[0];
        man_out   = man_out >> 1;
      end
    end
  end

endmodule

// File: rtl/fp_align_unit.sv
// Pre-add alignment: selects the larger operand and right-shifts the smaller
// mantissa into GRS. Define FP_ALIGN_BARREL_EN for a single-cycle SHIFT.
module fp_align_unit
  import fp_align_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_exp,
  input  logic [23:0]      a_man,
  input  logic [7:0]       b_exp,
  input  logic [23:0]      b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       exp_common,
  output logic [23:0]      man_large,
  output logic [23:0]      man_small,
  output logic             guard,
  output logic             round,
  output logic             sticky,
  output logic             swapped
);

  align_state_e       state_q, state_d;
  logic [EXP_W-1:0]   a_exp_q, a_exp_d, b_exp_q, b_exp_d;
  logic [MAN_W-1:0]   a_man_q, a_man_d, b_man_q, b_man_d;
  logic [SHIFT_W-1:0] rem_q, rem_d;
  logic [EXP_W-1:0]   exp_common_q, exp_common_d;
  logic [MAN_W-1:0]   man_large_q, man_large_d;
  logic [MAN_W-1:0]   man_small_q, man_small_d;
  grs_t               grs_q, grs_d;
  logic               swapped_q, swapped_d;

  logic               a_big;
  logic [EXP_W-1:0]   exp_diff;
  logic [SHIFT_W-1:0] rem_init;
  logic [SHIFT_W-1:0] shift_k;
  logic [MAN_W-1:0]   sh_man;
  grs_t               sh_grs;

  // Full tie (equal exponent and mantissa) keeps A as the larger operand.
  assign a_big    = (a_exp_q > b_exp_q) || ((a_exp_q == b_exp_q) && (a_man_q >= b_man_q));
  assign exp_diff = a_big ? (a_exp_q - b_exp_q) : (b_exp_q - a_exp_q);
  assign rem_init = (exp_diff > 8'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : exp_diff[SHIFT_W-1:0];

`ifdef FP_ALIGN_BARREL_EN
  assign shift_k = rem_q;
`else
  localparam logic [SHIFT_W-1:0] STEP_K = SHIFT_W'(SHIFT_STEP);
  assign shift_k = (rem_q < STEP_K) ? rem_q : STEP_K;
`endif

  align_shift_stage u_shift (
    .man_in  (man_small_q),
    .grs_in  (grs_q),
    .k       (shift_k),
    .man_out (sh_man),
    .grs_out (sh_grs)
  );

  always_comb begin
    state_d      = state_q;
    a_exp_d      = a_exp_q;
    a_man_d      = a_man_q;
    b_exp_d      = b_exp_q;
    b_man_d      = b_man_q;
    rem_d        = rem_q;
    exp_common_d = exp_common_q;
    man_large_d  = man_large_q;
    man_small_d  = man_small_q;
    grs_d        = grs_q;
    swapped_d    = swapped_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_exp_d = a_exp;
          a_man_d = a_man;
          b_exp_d = b_exp;
          b_man_d = b_man;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        exp_common_d = a_big ? a_exp_q : b_exp_q;
        man_large_d  = a_big ? a_man_q : b_man_q;
        man_small_d  = a_big ? b_man_q : a_man_q;
        grs_d        = '0;
        swapped_d    = ~a_big;
        rem_d        = rem_init;
        state_d      = (rem_init == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        man_small_d = sh_man;
        grs_d       = sh_grs;
        rem_d       = rem_q - shift_k;
        if (rem_q == shift_k) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      a_exp_q      <= '0;
      a_man_q      <= '0;
      b_exp_q      <= '0;
      b_man_q      <= '0;
      rem_q        <= '0;
      exp_common_q <= '0;
      man_large_q  <= '0;
      man_small_q  <= '0;
      grs_q        <= '0;
      swapped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_exp_q      <= a_exp_d;
      a_man_q      <= a_man_d;
      b_exp_q      <= b_exp_d;
      b_man_q      <= b_man_d;
      rem_q        <= rem_d;
      exp_common_q <= exp_common_d;
      man_large_q  <= man_large_d;
      man_small_q  <= man_small_d;
      grs_q        <= grs_d;
      swapped_q    <= swapped_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !Reset;
  assign out_valid  = (state_q == DONE);
  assign exp_common = exp_common_q;
  assign man_large  = man_large_q;
  assign man_small  = man_small_q;
  assign guard      = grs_q.g;
  assign round      = grs_q.r;
  assign sticky     = grs_q.s;
  assign swapped    = swapped_q;

endmodule
